// File: rtl/dcpu16_opf_if.sv
// Memory read bus between the DCPU16 operand-fetch stage (master) and memory (slave).
interface dcpu16_opf_if;
  logic [15:0] ab_adr;
  logic        ab_stb;
  logic        ab_ack;
  logic [15:0] ab_dti;

  modport master (output ab_adr, output ab_stb, input ab_ack, input ab_dti);
  modport slave  (input ab_adr, input ab_stb, output ab_ack, output ab_dti);
endinterface

// File: rtl/dcpu16_opf.sv
// DCPU16 operand-fetch stage: fetches instruction and next words, resolves a/b, owns PC and SP.
// Optional macro DCPU16_NBI_EN enables the non-basic JSR push/target sequence.
module dcpu16_opf #(
  parameter logic [15:0] RST_PC = 16'h0000,
  parameter logic [15:0] RST_SP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  dcpu16_opf_if.master ab,
  output logic [2:0]  rra,
  input  logic [15:0] rrd,
  input  logic [15:0] regO_i,
  input  logic        pc_ld,
  input  logic [15:0] pc_wd,
  output logic [3:0]  opc,
  output logic [15:0] regA,
  output logic [15:0] regB,
  output logic [2:0]  wb_sel,
  output logic [2:0]  wb_reg,
  output logic [15:0] wb_adr,
  output logic        opv,
  input  logic        opr,
  output logic [15:0] pc,
  output logic [15:0] sp
);

  typedef enum logic [1:0] {ST_FETCH, ST_OPA, ST_OPB, ST_ISSUE} state_e;
  typedef enum logic [1:0] {PH_DEC, PH_NW, PH_MEM} phase_e;

  localparam logic [2:0] WB_REG  = 3'd0;
  localparam logic [2:0] WB_MEM  = 3'd1;
  localparam logic [2:0] WB_SP   = 3'd2;
  localparam logic [2:0] WB_PC   = 3'd3;
  localparam logic [2:0] WB_O    = 3'd4;
  localparam logic [2:0] WB_DISC = 3'd5;

  state_e      state_q, state_d;
  phase_e      ph_q, ph_d;
  logic [15:0] ir_q, ir_d, pc_q, pc_d, sp_q, sp_d, adr_q, adr_d;
  logic        stb_q, stb_d, opv_q, opv_d;
  logic [2:0]  rra_q, rra_d, wbsel_q, wbsel_d, wbreg_q, wbreg_d;
  logic [3:0]  opc_q, opc_d;
  logic [15:0] rega_q, rega_d, regb_q, regb_d, wbadr_q, wbadr_d;

  logic [5:0]  f_s;
  logic        ack_s, done_s, jsr_s;
  logic [15:0] val_s, adr_s, jsp_s;
  logic [2:0]  sel_s;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;  ph_q <= PH_DEC;     ir_q <= 16'h0000;
      pc_q    <= RST_PC;    sp_q <= RST_SP;     adr_q <= 16'h0000;
      stb_q   <= 1'b0;      opv_q <= 1'b0;      rra_q <= 3'd0;
      opc_q   <= 4'h0;      rega_q <= 16'h0000; regb_q <= 16'h0000;
      wbsel_q <= 3'd0;      wbreg_q <= 3'd0;    wbadr_q <= 16'h0000;
    end else begin
      state_q <= state_d;   ph_q <= ph_d;       ir_q <= ir_d;
      pc_q    <= pc_d;      sp_q <= sp_d;       adr_q <= adr_d;
      stb_q   <= stb_d;     opv_q <= opv_d;     rra_q <= rra_d;
      opc_q   <= opc_d;     rega_q <= rega_d;   regb_q <= regb_d;
      wbsel_q <= wbsel_d;   wbreg_q <= wbreg_d; wbadr_q <= wbadr_d;
    end
  end

  // Next-state: fetch, per-field operand resolution and issue handshake
  always_comb begin
    state_d = state_q;  ph_d = ph_q;       ir_d = ir_q;     pc_d = pc_q;
    sp_d    = sp_q;     stb_d = stb_q;     adr_d = adr_q;   rra_d = rra_q;
    opc_d   = opc_q;    rega_d = rega_q;   regb_d = regb_q; opv_d = opv_q;
    wbsel_d = wbsel_q;  wbreg_d = wbreg_q; wbadr_d = wbadr_q;
    f_s    = (state_q == ST_OPB) ? ir_q[15:10] : ir_q[9:4];
    ack_s  = ab.ab_ack & stb_q;
    val_s  = 16'h0000;
    adr_s  = 16'h0000;
    sel_s  = WB_DISC;
    done_s = 1'b0;
    jsp_s  = 16'h0000;
`ifdef DCPU16_NBI_EN
    jsr_s  = (ir_q[3:0] == 4'h0) && (ir_q[9:4] == 6'h01);
`else
    jsr_s  = 1'b0;
`endif
    case (state_q)
      ST_FETCH: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          adr_d = pc_ld ? pc_wd : pc_q;
        end else if (ack_s) begin
          stb_d   = 1'b0;
          ir_d    = ab.ab_dti;
          pc_d    = pc_q + 16'd1;
          rra_d   = ab.ab_dti[6:4];
          ph_d    = PH_DEC;
          state_d = ST_OPA;
        end else begin
          stb_d = 1'b1;
        end
      end
      ST_OPA, ST_OPB: begin
        if ((state_q == ST_OPA) && jsr_s) begin
          rra_d   = ir_q[12:10];
          state_d = ST_OPB;
        end else begin
          case (ph_q)
            PH_DEC: begin
              if (f_s < 6'h08) begin
                val_s = rrd; sel_s = WB_REG; done_s = 1'b1;
              end else if (f_s < 6'h10) begin
                stb_d = 1'b1; adr_d = rrd; ph_d = PH_MEM;
              end else if ((f_s < 6'h18) || (f_s == 6'h1e) || (f_s == 6'h1f)) begin
                stb_d = 1'b1; adr_d = pc_q; ph_d = PH_NW;
              end else if (f_s >= 6'h20) begin
                val_s = {11'h000, f_s[4:0]}; sel_s = WB_DISC; done_s = 1'b1;
              end else begin
                case (f_s)
                  6'h18, 6'h19: begin stb_d = 1'b1; adr_d = sp_q; ph_d = PH_MEM; end
                  6'h1a: begin
                    sp_d = sp_q - 16'd1;
                    // A push destination needs only its address, never the old contents.
                    if (state_q == ST_OPA) begin
                      adr_s = sp_q - 16'd1; sel_s = WB_MEM; done_s = 1'b1;
                    end else begin
                      stb_d = 1'b1; adr_d = sp_q - 16'd1; ph_d = PH_MEM;
                    end
                  end
                  6'h1b:   begin val_s = sp_q;   sel_s = WB_SP; done_s = 1'b1; end
                  6'h1c:   begin val_s = pc_q;   sel_s = WB_PC; done_s = 1'b1; end
                  6'h1d:   begin val_s = regO_i; sel_s = WB_O;  done_s = 1'b1; end
                  default: done_s = 1'b0;
                endcase
              end
            end
            PH_NW: begin
              if (ack_s) begin
                pc_d = pc_q + 16'd1;
                if (f_s == 6'h1f) begin
                  stb_d = 1'b0; val_s = ab.ab_dti; sel_s = WB_DISC; done_s = 1'b1;
                end else begin
                  adr_d = (f_s == 6'h1e) ? ab.ab_dti : (ab.ab_dti + rrd);
                  ph_d  = PH_MEM;
                end
              end else begin
                stb_d = 1'b1;
              end
            end
            PH_MEM: begin
              if (ack_s) begin
                stb_d = 1'b0; val_s = ab.ab_dti; sel_s = WB_MEM; adr_s = adr_q; done_s = 1'b1;
                sp_d  = (f_s == 6'h18) ? (sp_q + 16'd1) : sp_q;
              end else begin
                stb_d = 1'b1;
              end
            end
            default: ph_d = PH_DEC;
          endcase
        end
        if (done_s) begin
          ph_d = PH_DEC;
          if (state_q == ST_OPA) begin
            rega_d  = val_s;   wbsel_d = sel_s;  wbreg_d = f_s[2:0];
            wbadr_d = adr_s;   rra_d = ir_q[12:10];
            state_d = ST_OPB;
          end else begin
            regb_d  = val_s;   opc_d = ir_q[3:0];
            opv_d   = 1'b1;    state_d = ST_ISSUE;
            if (jsr_s) begin
              jsp_s   = sp_d - 16'd1;
              sp_d    = jsp_s;  rega_d = jsp_s;
              wbsel_d = WB_MEM; wbadr_d = jsp_s;
            end else if (ir_q[3:0] == 4'h0) begin
              wbsel_d = WB_DISC;
            end else begin
              wbsel_d = wbsel_q;
            end
          end
        end else begin
          ph_d = ph_d;
        end
      end
      ST_ISSUE: begin
        if (opr) begin
          opv_d = 1'b0; state_d = ST_FETCH;
        end else begin
          opv_d = 1'b1;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    if (pc_ld) begin
      pc_d = pc_wd;
    end else begin
      pc_d = pc_d;
    end
  end

  assign ab.ab_adr = adr_q;
  assign ab.ab_stb = stb_q;
  assign rra    = rra_q;
  assign opc    = opc_q;
  assign regA   = rega_q;
  assign regB   = regb_q;
  assign wb_sel = wbsel_q;
  assign wb_reg = wbreg_q;
  assign wb_adr = wbadr_q;
  assign opv    = opv_q;
  assign pc     = pc_q;
  assign sp     = sp_q;

endmodule

// File: doc/dcpu16_opf.md
Name: dcpu16_opf

Overview:
- Operand-fetch stage directly upstream of the DCPU16 ALU.
- Fetches each instruction word and any "next word" literals over the memory bus, and decodes both 6-bit operand fields per DCPU-16 v1.1.
- Resolves register, memory, stack and literal operands into opc/regA/regB, plus a writeback descriptor for operand a.
- Owns PC and SP.

Parameters:
- RST_PC, 16'h0000, PC value loaded on reset.
- RST_SP, 16'h0000, SP value loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ab_adr  out  16  memory read address
- ab_stb  out  1  read strobe; held until ab_ack
- ab_ack  in  1  read complete; ab_dti valid this cycle
- ab_dti  in  16  memory read data
- rra  out  3  register-file read index
- rrd  in  16  register-file read data, combinational from rra
- regO_i  in  16  current O register (mode 0x1d)
- pc_ld  in  1  writeback loads PC
- pc_wd  in  16  PC load value
- opc  out  4  opcode to ALU
- regA  out  16  resolved a operand
- regB  out  16  resolved b operand
- wb_sel  out  3  a destination: 0 reg, 1 mem, 2 SP, 3 PC, 4 O, 5 discard (literal)
- wb_reg  out  3  register index when wb_sel=0
- wb_adr  out  16  memory address when wb_sel=1
- opv  out  1  operand bundle valid
- opr  in  1  downstream ready; transfer when opv&opr
- pc  out  16  current PC
- sp  out  16  current SP

Behaviour:
- Reset: pc=RST_PC, sp=RST_SP, all other outputs 0, state FETCH. Reset mid-transaction drops ab_stb immediately; a late ab_ack is ignored.
- Instruction format: opcode [3:0], a [9:4], b [15:10]. Operand a is resolved before b.
- Bus rules: ab_stb is asserted with a stable ab_adr until ab_ack. One outstanding read at a time. Every next-word read post-increments PC, wrapping at 16 bits.
- States:
  - FETCH: read [PC]; on ack latch IR, PC++, go OPA.
  - OPA: resolve a.
  - OPB: resolve b.
  - ISSUE: opv=1; hold all outputs stable until opr; then go FETCH.
- Operand resolve, per field f:
  - 0x00-07: value = rrd with rra=f[2:0]; 1 cycle.
  - 0x08-0f: address = rrd; memory read.
  - 0x10-17: next word (NW) read; address = NW + rrd (16-bit wrap); memory read.
  - 0x18 POP: address = SP; SP++ after the read.
  - 0x19 PEEK: address = SP.
  - 0x1a PUSH: SP--, then address = new SP. No read when it is operand a; the value is irrelevant and wb_sel=1.
  - 0x1b: SP value.
  - 0x1c: PC value, i.e. already incremented past this operand.
  - 0x1d: regO_i.
  - 0x1e: NW read, then address = NW; memory read.
  - 0x1f: NW literal; operand a uses wb_sel=5.
  - 0x20-3f: literal f-0x20; operand a uses wb_sel=5.
- Writeback descriptor for operand a: register modes give wb_sel=0; memory modes give wb_sel=1 with wb_adr = resolved address; 0x1b/0x1c/0x1d give 2/3/4.
- Stack wrap: SP wraps 0x0000 <-> 0xFFFF.
- Same-instruction SP updates: an SP change made by a is visible to b.
- Next-instruction SP updates: SP changes take effect before ISSUE.
- pc_ld: sampled in every state. Takes priority over the FETCH increment; applied the cycle it is seen. It is intended to be asserted only after an opv&opr transfer.
- opc=0 (non-basic): see Optional Feature.
- Latency:
  - register/literal operands: FETCH(≥1) + 1 + 1 + ISSUE.
  - each bus read: ≥1 added cycle.

Optional Feature:
- Macro: DCPU16_NBI_EN.
- With the macro: opc=0 with a[5:0]=0x01 (JSR) resolves b[15:10] as the target. It then pushes the return PC: SP--, and emits opc=0, regA=SP (push address), regB=target, wb_sel=1, wb_adr=SP. Downstream stores PC and loads PC via pc_ld.
- Without the macro: opc=0 decodes its operand fields normally, consuming next words, and issues opc=0 with wb_sel=5. It is a NOP-like instruction, and PC still advances.

Test Plan:
- mem[0]=0x7C01, mem[1]=0x0030 (SET A,0x30) -> opv with opc=1, regB=0x0030, wb_sel=0, wb_reg=0, pc=2.
- Register file B=0x1000 and mem[0x1002]=0xBEEF; instruction ADD [0x2+B],0x5 -> two bus reads; regA=0xBEEF, regB=5, wb_sel=1, wb_adr=0x1002.
- SP=0 after reset; SET PUSH,0x1F -> sp=0xFFFF, wb_adr=0xFFFF, no memory read on a. A following SET A,POP reads 0xFFFF and sp returns to 0.
- Hold opr=0 for 5 cycles during ISSUE -> opv and all outputs stable, no bus activity; transfer on opr=1, then FETCH.
- ab_ack delayed 3 cycles, then rst asserted mid-wait -> ab_stb=0, pc=RST_PC next cycle; a late ack is ignored.
- With DCPU16_NBI_EN: JSR 0x40 at pc=0 with sp=0 -> opc=0, regB=0x0040, wb_adr=0xFFFF, sp=0xFFFF. Without the macro: issued with wb_sel=5, sp unchanged.
